// File: rtl/c_stick_sprite_renderer.sv
// C-stick sprite pipeline stage: per-frame slew-limited sprite position from the stick axes,
// per-pixel ROM addressing, and colour-key transparency on the registered ROM data.
module c_stick_sprite_renderer #(
    parameter int          SPRITE_W    = 52,
    parameter int          SPRITE_H    = 52,
    parameter int          BASE_X      = 400,
    parameter int          BASE_Y      = 300,
    parameter int          SHIFT       = 2,
    parameter int          MAX_OFFSET  = 24,
    parameter int          MAX_STEP    = 4,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [7:0]  stick_x,
    input  logic [7:0]  stick_y,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic        pixel_valid,
    output logic [11:0] pixel_color
);

    localparam logic [9:0]         BASE_X10 = 10'(BASE_X);
    localparam logic [9:0]         BASE_Y10 = 10'(BASE_Y);
    localparam logic signed [10:0] BASE_X11 = 11'(BASE_X);
    localparam logic signed [10:0] BASE_Y11 = 11'(BASE_Y);
    localparam logic signed [10:0] W11      = 11'(SPRITE_W);
    localparam logic signed [10:0] H11      = 11'(SPRITE_H);
    localparam logic signed [8:0]  OFF9     = 9'(MAX_OFFSET);
    localparam logic signed [11:0] STEP12   = 12'(MAX_STEP);
    localparam logic [9:0]         STEP10   = 10'(MAX_STEP);

    logic [9:0]         cur_x;
    logic [9:0]         cur_y;
    logic signed [10:0] off_x;
    logic signed [10:0] off_y;
    logic signed [10:0] tgt_x;
    logic signed [10:0] tgt_y;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               in_box;
    logic               v1;
    logic               v2;
    logic               opaque;

    function automatic logic signed [10:0] stick_offset(input logic [7:0] stick);
        logic signed [8:0] s;
        logic signed [8:0] o;
        s = $signed({1'b0, stick}) - 9'sd128;
        o = s >>> SHIFT;
        if (o > OFF9)
            o = OFF9;
        else if (o < -OFF9)
            o = -OFF9;
        return {{2{o[8]}}, o};
    endfunction

    function automatic logic [9:0] slew(input logic [9:0] cur, input logic signed [10:0] tgt);
        logic signed [11:0] diff;
        diff = {tgt[10], tgt} - $signed({2'b00, cur});
        if (diff > STEP12)
            return cur + STEP10;
        else if (diff < -STEP12)
            return cur - STEP10;
        else
            return cur + diff[9:0];
    endfunction

    // Stick "up" raises the sprite, hence the subtraction on y.
    assign off_x = stick_offset(stick_x);
    assign off_y = stick_offset(stick_y);
    assign tgt_x = BASE_X11 + off_x;
    assign tgt_y = BASE_Y11 - off_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x <= BASE_X10;
            cur_y <= BASE_Y10;
        end else if (frame_start) begin
            cur_x <= slew(cur_x, tgt_x);
            cur_y <= slew(cur_y, tgt_y);
        end
    end

    assign dx     = $signed({1'b0, x}) - $signed({1'b0, cur_x});
    assign dy     = $signed({1'b0, y}) - $signed({1'b0, cur_y});
    assign in_box = video_on && (dx >= 11'sd0) && (dx < W11) && (dy >= 11'sd0) && (dy < H11);
    assign opaque = v2 && (rom_color != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_row     <= '0;
            rom_col     <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_color <= '0;
        end else begin
            rom_col     <= in_box ? dx[5:0] : 6'd0;
            rom_row     <= in_box ? dy[5:0] : 6'd0;
            v1          <= in_box;
            v2          <= v1;
            pixel_valid <= opaque;
            pixel_color <= opaque ? rom_color : 12'h000;
        end
    end

endmodule

// File: tb/tb_c_stick_sprite_renderer.sv
// Bench for c_stick_sprite_renderer: table vectors plus scoreboard of expected pixels,
// with a registered ROM model and an independent position model.
module tb_c_stick_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  stick_x = 8'd128;
    logic [7:0]  stick_y = 8'd128;
    logic [5:0]  rom_row;
    logic [5:0]  rom_col;
    logic [11:0] rom_color = '0;
    logic        pixel_valid;
    logic [11:0] pixel_color;

    int passed = 0;
    int total  = 0;
    int mcx = 400;
    int mcy = 300;

    typedef struct {
        logic [5:0]  row;
        logic [5:0]  col;
        logic        valid;
        logic [11:0] color;
    } exp_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        exp_t       e;
    } vec_t;

    exp_t q[$];

    c_stick_sprite_renderer dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_start(frame_start), .stick_x(stick_x), .stick_y(stick_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color)
    );

    always #5 clk = ~clk;

    // Sprite content: origin FE3, diagonal transparent, elsewhere {row,col}.
    function automatic logic [11:0] rom_fn(input logic [5:0] r, input logic [5:0] c);
        if (r == 6'd0 && c == 6'd0) return 12'hFE3;
        if (r == c) return 12'h000;
        return {r, c};
    endfunction

    always @(posedge clk) rom_color <= rom_fn(rom_row, rom_col);

    function automatic int moff(input logic [7:0] st);
        int s;
        int o;
        s = int'(st) - 128;
        o = s >>> 2;
        if (o > 24) o = 24;
        if (o < -24) o = -24;
        return o;
    endfunction

    function automatic int mstep(input int cur, input int tgt);
        if (tgt > cur) return cur + ((tgt - cur) > 4 ? 4 : (tgt - cur));
        if (tgt < cur) return cur - ((cur - tgt) > 4 ? 4 : (cur - tgt));
        return cur;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    task automatic drive(input logic [9:0] xi, input logic [9:0] yi, input logic von,
                         input logic fs, input logic rst, input exp_t ei);
        exp_t e;
        exp_t f;
        e = ei;
        x = xi; y = yi; video_on = von; frame_start = fs; reset = rst;
        if (rst) begin
            for (int i = 0; i < q.size(); i++) begin
                f = q[i];
                f.valid = 1'b0;
                f.color = 12'h000;
                q[i] = f;
            end
            e.row = 6'd0; e.col = 6'd0; e.valid = 1'b0; e.color = 12'h000;
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check("rom_addr", int'({rom_row, rom_col}), int'({e.row, e.col}));
        if (q.size() == 3) begin
            f = q.pop_front();
            check("pixel_valid", int'(pixel_valid), int'(f.valid));
            check("pixel_color", int'(pixel_color), int'(f.color));
        end
    endtask

    task automatic px(input int xi, input int yi, input logic von, input logic fs, input logic rst);
        exp_t e;
        int dx;
        int dy;
        logic inb;
        dx  = xi - mcx;
        dy  = yi - mcy;
        inb = von && dx >= 0 && dx < 52 && dy >= 0 && dy < 52;
        e.row   = inb ? 6'(dy) : 6'd0;
        e.col   = inb ? 6'(dx) : 6'd0;
        e.valid = inb && (rom_fn(e.row, e.col) != 12'h000);
        e.color = e.valid ? rom_fn(e.row, e.col) : 12'h000;
        drive(10'(xi), 10'(yi), von, fs, rst, e);
        if (rst) begin
            mcx = 400;
            mcy = 300;
        end else if (fs) begin
            mcx = mstep(mcx, 400 + moff(stick_x));
            mcy = mstep(mcy, 300 - moff(stick_y));
        end
    endtask

    vec_t vecs[10];
    int   exp3[7];

    initial begin
        vecs[0] = '{10'd400, 10'd300, 1'b1, '{6'd0,  6'd0,  1'b1, 12'hFE3}};
        vecs[1] = '{10'd401, 10'd301, 1'b1, '{6'd1,  6'd1,  1'b0, 12'h000}};
        vecs[2] = '{10'd451, 10'd300, 1'b1, '{6'd0,  6'd51, 1'b1, 12'h033}};
        vecs[3] = '{10'd452, 10'd300, 1'b1, '{6'd0,  6'd0,  1'b0, 12'h000}};
        vecs[4] = '{10'd399, 10'd300, 1'b1, '{6'd0,  6'd0,  1'b0, 12'h000}};
        vecs[5] = '{10'd400, 10'd300, 1'b0, '{6'd0,  6'd0,  1'b0, 12'h000}};
        vecs[6] = '{10'd410, 10'd351, 1'b1, '{6'd51, 6'd10, 1'b1, 12'hCCA}};
        vecs[7] = '{10'd410, 10'd352, 1'b1, '{6'd0,  6'd0,  1'b0, 12'h000}};
        vecs[8] = '{10'd410, 10'd299, 1'b1, '{6'd0,  6'd0,  1'b0, 12'h000}};
        vecs[9] = '{10'd420, 10'd305, 1'b1, '{6'd5,  6'd20, 1'b1, 12'h154}};
        exp3 = '{404, 408, 412, 416, 420, 424, 424};

        // Reset state and centred stick
        px(0, 0, 1'b0, 1'b0, 1'b1);
        px(0, 0, 1'b0, 1'b0, 1'b1);
        check("reset_valid", int'(pixel_valid), 0);
        check("reset_color", int'(pixel_color), 0);
        check("reset_cur_x", int'(dut.cur_x), 400);
        check("reset_cur_y", int'(dut.cur_y), 300);
        px(0, 0, 1'b0, 1'b1, 1'b0);
        check("centre_cur_x", int'(dut.cur_x), 400);

        for (int i = 0; i < 10; i++)
            drive(vecs[i].x, vecs[i].y, vecs[i].von, 1'b0, 1'b0, vecs[i].e);

        // Right extreme: offset clamps at +24, slews 4 px per frame
        px(0, 0, 1'b0, 1'b0, 1'b1);
        stick_x = 8'd255;
        for (int i = 0; i < 7; i++) begin
            px(0, 0, 1'b0, 1'b1, 1'b0);
            check("slew_cur_x", int'(dut.cur_x), exp3[i]);
        end
        px(424, 300, 1'b1, 1'b0, 1'b0);
        px(475, 310, 1'b1, 1'b0, 1'b0);
        px(476, 300, 1'b1, 1'b0, 1'b0);
        px(423, 300, 1'b1, 1'b0, 1'b0);

        // Down extreme then back to centre
        stick_y = 8'd0;
        for (int i = 0; i < 6; i++) px(0, 0, 1'b0, 1'b1, 1'b0);
        check("down_cur_y", int'(dut.cur_y), 324);
        px(0, 0, 1'b0, 1'b1, 1'b0);
        check("down_hold_y", int'(dut.cur_y), 324);
        px(430, 330, 1'b1, 1'b0, 1'b0);
        px(430, 323, 1'b1, 1'b0, 1'b0);
        stick_y = 8'd128;
        for (int i = 0; i < 6; i++) px(0, 0, 1'b0, 1'b1, 1'b0);
        check("centre_cur_y", int'(dut.cur_y), 300);

        // frame_start coincident with an in-box pixel
        stick_x = 8'd128;
        px(424, 300, 1'b1, 1'b1, 1'b0);
        px(424, 300, 1'b1, 1'b0, 1'b0);
        check("fs_cur_x", int'(dut.cur_x), 420);
        px(419, 300, 1'b1, 1'b0, 1'b0);
        px(420, 302, 1'b1, 1'b0, 1'b0);

        // Reset with pixels in flight
        px(0, 0, 1'b0, 1'b0, 1'b1);
        stick_x = 8'd255;
        for (int i = 0; i < 3; i++) px(0, 0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_cur_x", int'(dut.cur_x), 412);
        stick_x = 8'd128;
        px(412, 300, 1'b1, 1'b0, 1'b0);
        px(413, 300, 1'b1, 1'b0, 1'b0);
        px(414, 300, 1'b1, 1'b0, 1'b1);
        check("rst_cur_x", int'(dut.cur_x), 400);
        check("rst_pixel_valid", int'(pixel_valid), 0);
        px(0, 0, 1'b1, 1'b0, 1'b0);
        px(0, 0, 1'b1, 1'b0, 1'b0);
        px(0, 0, 1'b1, 1'b0, 1'b0);
        px(400, 300, 1'b1, 1'b0, 1'b0);
        px(402, 301, 1'b1, 1'b0, 1'b0);
        px(0, 0, 1'b0, 1'b0, 1'b0);
        px(0, 0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
